// File: rtl/rs_pipelined_alu.sv
// Pipelined wide adder/subtractor. The Y_WIDTH-bit sum is split into
// SEG_WIDTH-bit segments, one per pipeline stage, with the inter-segment
// carry registered between stages. Operand segments are skewed in and
// sum segments de-skewed out, so one full result emerges per EN cycle.

`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

module rs_pipelined_alu #(
    parameter int A_WIDTH   = 32,
    parameter int B_WIDTH   = 32,
    parameter bit A_SIGNED  = 1'b0,
    parameter bit B_SIGNED  = 1'b0,
    parameter int Y_WIDTH   = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic               C,
    input  logic               R,
    input  logic               EN,
    input  logic               IN_VALID,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic               CI,
    input  logic               BI,
    output logic               OUT_VALID,
    output logic [Y_WIDTH-1:0] Y,
    output logic               CO,
    output logic               OV
);

    // Guarded divisor so an illegal SEG_WIDTH reports through the check
    // below instead of a divide-by-zero during elaboration.
    localparam int SEG_SAFE = (SEG_WIDTH < 1) ? 1 : SEG_WIDTH;
    localparam int NSEG     = (Y_WIDTH + SEG_SAFE - 1) / SEG_SAFE;

    if (SEG_WIDTH < 1 || SEG_WIDTH > `MAX_CARRY_CHAIN || Y_WIDTH < 2) begin : g_param_check
        $error("rs_pipelined_alu: illegal parameters Y_WIDTH=%0d SEG_WIDTH=%0d",
               Y_WIDTH, SEG_WIDTH);
    end

    logic [Y_WIDTH-1:0] aa;
    logic [Y_WIDTH-1:0] b_ext;
    logic [Y_WIDTH-1:0] bb;
    wire  [NSEG:0]      seg_carry;
    wire  [Y_WIDTH-1:0] y_all;
    logic [NSEG-1:0]    valid_q;

    // Operand extension to the full result width.
    if (A_SIGNED) begin : g_a_sext
        logic signed [A_WIDTH-1:0] a_s;
        assign a_s = A;
        assign aa  = Y_WIDTH'(a_s);
    end else begin : g_a_zext
        assign aa = Y_WIDTH'(A);
    end

    if (B_SIGNED) begin : g_b_sext
        logic signed [B_WIDTH-1:0] b_s;
        assign b_s   = B;
        assign b_ext = Y_WIDTH'(b_s);
    end else begin : g_b_zext
        assign b_ext = Y_WIDTH'(B);
    end

    assign bb           = BI ? ~b_ext : b_ext;
    assign seg_carry[0] = CI;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * SEG_SAFE;
        localparam int W  = (k == NSEG - 1) ? (Y_WIDTH - LO) : SEG_SAFE;
        localparam int D  = NSEG - 1 - k;

        logic [W-1:0] a_op;
        logic [W-1:0] b_op;
        logic [W:0]   seg_sum;
        logic [W-1:0] sum_q;
        logic         carry_q;

        if (k == 0) begin : g_noskew
            assign a_op = aa[LO +: W];
            assign b_op = bb[LO +: W];
        end else begin : g_skew
            logic [W-1:0] a_dly [k];
            logic [W-1:0] b_dly [k];

            // Skew registers: delay this segment's operands k cycles so they
            // meet the carry produced by the previous stage.
            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    for (int i = 0; i < k; i++) begin
                        a_dly[i] <= '0;
                        b_dly[i] <= '0;
                    end
                end else if (EN) begin
                    a_dly[0] <= aa[LO +: W];
                    b_dly[0] <= bb[LO +: W];
                    for (int i = 1; i < k; i++) begin
                        a_dly[i] <= a_dly[i-1];
                        b_dly[i] <= b_dly[i-1];
                    end
                end
            end

            assign a_op = a_dly[k-1];
            assign b_op = b_dly[k-1];
        end

        assign seg_sum = {1'b0, a_op} + {1'b0, b_op} + {{W{1'b0}}, seg_carry[k]};

        // Stage register: captures this segment's sum bits and its carry out.
        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (EN) begin
                sum_q   <= seg_sum[W-1:0];
                carry_q <= seg_sum[W];
            end
        end

        assign seg_carry[k+1] = carry_q;

        if (D == 0) begin : g_nodeskew
            assign y_all[LO +: W] = sum_q;
        end else begin : g_deskew
            logic [W-1:0] s_dly [D];

            // De-skew registers: hold early segments back so every segment of
            // one result reaches the output on the same cycle.
            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    for (int i = 0; i < D; i++) begin
                        s_dly[i] <= '0;
                    end
                end else if (EN) begin
                    s_dly[0] <= sum_q;
                    for (int i = 1; i < D; i++) begin
                        s_dly[i] <= s_dly[i-1];
                    end
                end
            end

            assign y_all[LO +: W] = s_dly[D-1];
        end

        if (k == NSEG - 1) begin : g_top
            logic ov_q;

            // Signed overflow, registered alongside the top segment using the
            // operand MSBs that travelled down the skew pipe with it.
            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    ov_q <= 1'b0;
                end else if (EN) begin
                    ov_q <= (a_op[W-1] == b_op[W-1]) && (seg_sum[W-1] != a_op[W-1]);
                end
            end

            assign OV = ov_q;
        end
    end

    // Valid pipe: shifts IN_VALID alongside the data, one step per EN cycle.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            valid_q <= '0;
        end else if (EN) begin
            valid_q[0] <= IN_VALID;
            for (int i = 1; i < NSEG; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign OUT_VALID = valid_q[NSEG-1];
    assign Y         = y_all;
    assign CO        = seg_carry[NSEG];

endmodule

// File: tb/tb_rs_pipelined_alu.sv
// Self-checking bench for rs_pipelined_alu: 64-bit/16-bit-segment instance
// checked against a queue-based reference pipeline, plus a 40-bit instance
// with a narrow signed operand and a short final segment.

module tb_rs_pipelined_alu;

    localparam int NSEG = 4;

    typedef struct packed {
        logic        v;
        logic [63:0] y;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        bi;
    logic        out_valid;
    logic [63:0] y;
    logic        co;
    logic        ov;

    logic        in_valid2;
    logic [7:0]  a2;
    logic [31:0] b2;
    logic        out_valid2;
    logic [39:0] y2;
    logic        co2;
    logic        ov2;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    rs_pipelined_alu #(
        .A_WIDTH(64), .B_WIDTH(64), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
        .Y_WIDTH(64), .SEG_WIDTH(16)
    ) dut (
        .C(clk), .R(rst_n), .EN(en), .IN_VALID(in_valid),
        .A(a), .B(b), .CI(ci), .BI(bi),
        .OUT_VALID(out_valid), .Y(y), .CO(co), .OV(ov)
    );

    rs_pipelined_alu #(
        .A_WIDTH(8), .B_WIDTH(32), .A_SIGNED(1'b1), .B_SIGNED(1'b0),
        .Y_WIDTH(40), .SEG_WIDTH(16)
    ) dut40 (
        .C(clk), .R(rst_n), .EN(1'b1), .IN_VALID(in_valid2),
        .A(a2), .B(b2), .CI(1'b0), .BI(1'b0),
        .OUT_VALID(out_valid2), .Y(y2), .CO(co2), .OV(ov2)
    );

    always #5 clk = ~clk;

    function automatic exp_t refModel(input logic vin, input logic [63:0] ra,
                                      input logic [63:0] rb, input logic rci,
                                      input logic rbi);
        exp_t        e;
        logic [63:0] bbv;
        logic [64:0] full;
        bbv  = rbi ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bbv} + {64'd0, rci};
        e.v  = vin;
        e.y  = full[63:0];
        e.co = full[64];
        e.ov = (ra[63] == bbv[63]) && (full[63] != ra[63]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [63:0] av,
                                 input logic [63:0] bv, input logic civ,
                                 input logic biv);
        in_valid = iv;
        a        = av;
        b        = bv;
        ci       = civ;
        bi       = biv;
    endtask

    // One clock: the scoreboard takes the op on the edge, the DUT is compared
    // against the oldest entry on the following falling edge.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        if (rst_n && en) begin
            sb.push_back(refModel(in_valid, a, b, ci, bi));
            if (sb.size() > NSEG) void'(sb.pop_front());
        end
        @(negedge clk);
        if (sb.size() == NSEG) e = sb[0];
        else                   e = '0;
        checkOutput({tag, ".valid"}, {63'd0, out_valid}, {63'd0, e.v});
        if (e.v) begin
            checkOutput({tag, ".y"},  y, e.y);
            checkOutput({tag, ".co"}, {63'd0, co}, {63'd0, e.co});
            checkOutput({tag, ".ov"}, {63'd0, ov}, {63'd0, e.ov});
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid2 = 1'b0;
        a2        = '0;
        b2        = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("reset.valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset.y",     y, 64'd0);
        checkOutput("reset.co",    {63'd0, co}, 64'd0);
        checkOutput("reset.ov",    {63'd0, ov}, 64'd0);
        checkOutput("reset.valid40", {63'd0, out_valid2}, 64'd0);
        rst_n = 1'b1;

        $display("[TB] carry ripple across all segments");
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick("ripple");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) tick("ripple");
        checkOutput("ripple.const.valid", {63'd0, out_valid}, 64'd1);
        checkOutput("ripple.const.y",     y, 64'd0);
        checkOutput("ripple.const.co",    {63'd0, co}, 64'd1);
        checkOutput("ripple.const.ov",    {63'd0, ov}, 64'd0);

        $display("[TB] subtraction and signed overflow");
        applyStimulus(1'b1, 64'd0, 64'd1, 1'b1, 1'b1);
        tick("sub");
        applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
        tick("sub");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) tick("sub");
        checkOutput("sub0.y",  y, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("sub0.co", {63'd0, co}, 64'd0);
        checkOutput("sub0.ov", {63'd0, ov}, 64'd0);
        tick("sub");
        checkOutput("sub1.y",  y, 64'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("sub1.ov", {63'd0, ov}, 64'd1);
        repeat (3) tick("sub");

        $display("[TB] random stream with an EN stall");
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                                  {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
                    tick("stall");
                end
                en = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                          {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            tick("stream");
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (NSEG) tick("drain");

        $display("[TB] asynchronous reset with ops in flight");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            tick("preflight");
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async.valid", {63'd0, out_valid}, 64'd0);
        checkOutput("async.y",     y, 64'd0);
        checkOutput("async.co",    {63'd0, co}, 64'd0);
        checkOutput("async.ov",    {63'd0, ov}, 64'd0);
        sb.delete();
        repeat (2) tick("inreset");
        rst_n = 1'b1;
        repeat (5) tick("postreset");
        applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        tick("firstop");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (NSEG) tick("firstop");

        $display("[TB] 40-bit instance, signed 8-bit operand");
        a2        = 8'h80;
        b2        = 32'd0;
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("w40.early", {63'd0, out_valid2}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("w40.valid", {63'd0, out_valid2}, 64'd1);
        checkOutput("w40.y",     {24'd0, y2}, {24'd0, 40'hFF_FFFF_FF80});
        checkOutput("w40.co",    {63'd0, co2}, 64'd0);
        checkOutput("w40.ov",    {63'd0, ov2}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("w40.after", {63'd0, out_valid2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
